multi_queue_fifo_writer: RTL and testbench

//  Write-side front end of multi_queue_fifo. Merges SRC_COUNT independent source streams, each

---
 rtl/multi_queue_fifo_writer.sv | 133 +++++++++++++
 tb/tb_multi_queue_fifo_writer.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/multi_queue_fifo_writer.sv
// ============================================================================
//  Module      : multi_queue_fifo_writer
//  Description : Round-robin merge of tagged source streams into one registered
//                beat toward a multi-queue fifo; illegal targets are dropped.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module multi_queue_fifo_writer #(
    parameter int SRC_COUNT   = 2,
    parameter int QUEUE_COUNT = 2,
    parameter int DATA_WIDTH  = 32,
    localparam int TW = (QUEUE_COUNT > 1) ? $clog2(QUEUE_COUNT) : 1,
    localparam int SW = (SRC_COUNT > 1) ? $clog2(SRC_COUNT) : 1
) (
    input  wire logic                            clk,
    input  wire logic                            rst_n,
    input  wire logic [SRC_COUNT-1:0]            i_src_valid,
    output logic      [SRC_COUNT-1:0]            o_src_ready,
    input  wire logic [SRC_COUNT*TW-1:0]         i_src_target,
    input  wire logic [SRC_COUNT*DATA_WIDTH-1:0] i_src_payload,
    output logic                                 o_out_valid,
    output logic      [TW-1:0]                   o_out_target,
    output logic      [DATA_WIDTH-1:0]           o_out_payload,
    input  wire logic [QUEUE_COUNT-1:0]          i_out_ready,
    output logic                                 o_err_target,
    output logic      [SW-1:0]                   o_err_src
);

    localparam logic [TW:0]   c_Q_LIMIT = (TW+1)'(QUEUE_COUNT);
    localparam logic [SW-1:0] c_LAST    = SW'(SRC_COUNT - 1);

    logic                  r_out_valid;
    logic [TW-1:0]         r_out_target;
    logic [DATA_WIDTH-1:0] r_out_payload;
    logic                  r_err_target;
    logic [SW-1:0]         r_err_src;
    logic [SW-1:0]         r_rr_ptr;

    logic                  w_drain;
    logic                  w_load_en;
    logic [SRC_COUNT-1:0]  w_legal;
    logic [SRC_COUNT-1:0]  w_elig;
    logic                  w_grant_found;
    logic [SW-1:0]         w_grant_idx;
    logic [SRC_COUNT-1:0]  w_grant_mask;
    logic                  w_drop_found;
    logic [SW-1:0]         w_drop_idx;
    logic [SRC_COUNT-1:0]  w_drop_mask;
    int                    w_scan;
    logic [TW-1:0]         w_grant_target;
    logic [DATA_WIDTH-1:0] w_grant_payload;

    assign w_drain   = r_out_valid && i_out_ready[r_out_target];
    assign w_load_en = !r_out_valid || w_drain;

    always_comb begin
        w_legal       = '0;
        w_elig        = '0;
        w_grant_found = 1'b0;
        w_grant_idx   = '0;
        w_grant_mask  = '0;
        w_drop_found  = 1'b0;
        w_drop_idx    = '0;
        w_drop_mask   = '0;
        w_scan        = 0;
        for (int k = 0; k < SRC_COUNT; k++) begin
            w_legal[k] = {1'b0, i_src_target[k*TW +: TW]} < c_Q_LIMIT;
            w_elig[k]  = i_src_valid[k] && w_legal[k];
        end
        // Descending scan so the lowest-index illegal source is the one dropped
        for (int k = SRC_COUNT - 1; k >= 0; k--) begin
            if (i_src_valid[k] && !w_legal[k]) begin
                w_drop_found = 1'b1;
                w_drop_idx   = SW'(k);
            end
        end
        if (w_drop_found) begin
            w_drop_mask[w_drop_idx] = 1'b1;
        end
        for (int k = 0; k < SRC_COUNT; k++) begin
            w_scan = (int'(r_rr_ptr) + k) % SRC_COUNT;
            if (w_load_en && !w_grant_found && w_elig[w_scan]) begin
                w_grant_found = 1'b1;
                w_grant_idx   = SW'(w_scan);
            end
        end
        if (w_grant_found) begin
            w_grant_mask[w_grant_idx] = 1'b1;
        end
    end

    assign w_grant_target  = i_src_target[int'(w_grant_idx)*TW +: TW];
    assign w_grant_payload = i_src_payload[int'(w_grant_idx)*DATA_WIDTH +: DATA_WIDTH];

    // Nothing is consumed while reset is asserted
    assign o_src_ready = rst_n ? (w_grant_mask | w_drop_mask) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid   <= 1'b0;
            r_out_target  <= '0;
            r_out_payload <= '0;
            r_err_target  <= 1'b0;
            r_err_src     <= '0;
            r_rr_ptr      <= '0;
        end else begin
            if (w_load_en) begin
                if (w_grant_found) begin
                    r_out_valid   <= 1'b1;
                    r_out_target  <= w_grant_target;
                    r_out_payload <= w_grant_payload;
                    r_rr_ptr      <= (w_grant_idx == c_LAST) ? '0 : w_grant_idx + 1'b1;
                end else begin
                    r_out_valid   <= 1'b0;
                end
            end
            r_err_target <= w_drop_found;
            if (w_drop_found) begin
                r_err_src <= w_drop_idx;
            end
        end
    end

    assign o_out_valid   = r_out_valid;
    assign o_out_target  = r_out_target;
    assign o_out_payload = r_out_payload;
    assign o_err_target  = r_err_target;
    assign o_err_src     = r_err_src;

endmodule

`default_nettype wire

// File: tb/tb_multi_queue_fifo_writer.sv
// ============================================================================
//  Module      : tb_multi_queue_fifo_writer
//  Description : Directed self-checking bench, two sources and three queues.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multi_queue_fifo_writer;

    localparam int SRC_COUNT   = 2;
    localparam int QUEUE_COUNT = 3;
    localparam int DATA_WIDTH  = 32;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  src_valid;
    logic [1:0]  src_ready;
    logic [3:0]  src_target;
    logic [63:0] src_payload;
    logic        out_valid;
    logic [1:0]  out_target;
    logic [31:0] out_payload;
    logic [2:0]  out_ready;
    logic        err_target;
    logic        err_src;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    multi_queue_fifo_writer #(
        .SRC_COUNT   (SRC_COUNT),
        .QUEUE_COUNT (QUEUE_COUNT),
        .DATA_WIDTH  (DATA_WIDTH)
    ) u_dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_src_valid   (src_valid),
        .o_src_ready   (src_ready),
        .i_src_target  (src_target),
        .i_src_payload (src_payload),
        .o_out_valid   (out_valid),
        .o_out_target  (out_target),
        .o_out_payload (out_payload),
        .i_out_ready   (out_ready),
        .o_err_target  (err_target),
        .o_err_src     (err_src)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] pay(input int src, input int n);
        return 32'hA000_0000 | (32'(src) << 16) | 32'(n);
    endfunction

    initial begin
        src_valid   = 2'b00;
        src_target  = 4'h0;
        src_payload = 64'h0;
        out_ready   = 3'b000;

        // Reset state
        #1;
        check("rst_out_valid",  64'(out_valid),   64'd0);
        check("rst_out_target", 64'(out_target),  64'd0);
        check("rst_out_payload",64'(out_payload), 64'd0);
        check("rst_err_target", 64'(err_target),  64'd0);
        check("rst_err_src",    64'(err_src),     64'd0);
        check("rst_src_ready",  64'(src_ready),   64'd0);
        tick;
        tick;
        rst_n = 1'b1;

        // Throughput: alternate grants, one beat per cycle
        for (int i = 0; i < 8; i++) begin
            src_valid   = 2'b11;
            src_target  = {2'd1, 2'd0};
            src_payload = {pay(1, i), pay(0, i)};
            out_ready   = 3'b011;
            #1;
            check("tput_src_ready", 64'(src_ready), (i % 2 == 0) ? 64'd1 : 64'd2);
            tick;
            check("tput_out_valid",   64'(out_valid),   64'd1);
            check("tput_out_target",  64'(out_target),  64'(i % 2));
            check("tput_out_payload", 64'(out_payload), 64'(pay(i % 2, i)));
        end

        // Backpressure on queue 1 while queue 0 is ready
        src_payload = {pay(1, 8), pay(0, 8)};
        out_ready   = 3'b001;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("bp_src_ready", 64'(src_ready), 64'd0);
            tick;
            check("bp_out_valid",   64'(out_valid),   64'd1);
            check("bp_out_target",  64'(out_target),  64'd1);
            check("bp_out_payload", 64'(out_payload), 64'(pay(1, 7)));
        end
        out_ready = 3'b010;
        #1;
        check("bp_release_ready", 64'(src_ready), 64'd1);
        tick;
        check("bp_new_target",  64'(out_target),  64'd0);
        check("bp_new_payload", 64'(out_payload), 64'(pay(0, 8)));

        // Illegal target dropped while holding
        out_ready   = 3'b000;
        src_valid   = 2'b01;
        src_target  = {2'd1, 2'd3};
        src_payload = {pay(1, 9), pay(0, 9)};
        #1;
        check("ill_src_ready", 64'(src_ready), 64'd1);
        tick;
        check("ill_err_target",  64'(err_target),  64'd1);
        check("ill_err_src",     64'(err_src),     64'd0);
        check("ill_hold_target", 64'(out_target),  64'd0);
        check("ill_hold_payload",64'(out_payload), 64'(pay(0, 8)));
        src_valid = 2'b00;
        out_ready = 3'b001;
        tick;
        check("ill_err_clear", 64'(err_target), 64'd0);
        check("ill_empty",     64'(out_valid),  64'd0);

        // Drop and grant in the same cycle; queue 2 is the highest legal target
        out_ready   = 3'b000;
        src_valid   = 2'b11;
        src_target  = {2'd2, 2'd3};
        src_payload = {pay(1, 10), pay(0, 10)};
        #1;
        check("dual_src_ready", 64'(src_ready), 64'd3);
        tick;
        check("dual_out_valid",   64'(out_valid),   64'd1);
        check("dual_out_target",  64'(out_target),  64'd2);
        check("dual_out_payload", 64'(out_payload), 64'(pay(1, 10)));
        check("dual_err_target",  64'(err_target),  64'd1);
        check("dual_err_src",     64'(err_src),     64'd0);

        // Source 1 illegal while queue 2 drains
        src_valid  = 2'b10;
        src_target = {2'd3, 2'd0};
        out_ready  = 3'b100;
        #1;
        check("ill1_src_ready", 64'(src_ready), 64'd2);
        tick;
        check("ill1_out_valid",  64'(out_valid),  64'd0);
        check("ill1_err_target", 64'(err_target), 64'd1);
        check("ill1_err_src",    64'(err_src),    64'd1);

        // Round-robin pointer behaviour
        src_valid   = 2'b01;
        src_target  = {2'd0, 2'd0};
        src_payload = {pay(1, 11), pay(0, 11)};
        out_ready   = 3'b001;
        #1;
        check("rr_first_ready", 64'(src_ready), 64'd1);
        tick;
        src_payload = {pay(1, 12), pay(0, 12)};
        #1;
        check("rr_wrap_ready", 64'(src_ready), 64'd1);
        tick;
        check("rr_wrap_payload", 64'(out_payload), 64'(pay(0, 12)));
        src_valid   = 2'b11;
        src_target  = {2'd1, 2'd0};
        src_payload = {pay(1, 13), pay(0, 13)};
        #1;
        check("rr_both_ready", 64'(src_ready), 64'd2);
        tick;
        check("rr_both_target",  64'(out_target),  64'd1);
        check("rr_both_payload", 64'(out_payload), 64'(pay(1, 13)));

        // Asynchronous reset mid-beat with an error pending
        out_ready  = 3'b000;
        src_valid  = 2'b01;
        src_target = {2'd0, 2'd3};
        tick;
        check("pre_rst_err", 64'(err_target), 64'd1);
        src_valid  = 2'b11;
        src_target = {2'd1, 2'd0};
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid",   64'(out_valid),   64'd0);
        check("arst_src_ready",   64'(src_ready),   64'd0);
        check("arst_err_target",  64'(err_target),  64'd0);
        check("arst_out_payload", 64'(out_payload), 64'd0);
        tick;
        check("arst_no_accept", 64'(out_valid), 64'd0);
        src_valid = 2'b00;
        rst_n     = 1'b1;
        tick;
        check("post_rst_idle", 64'(out_valid), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
